// File: rtl/fifo_pkg.sv
// Shared FIFO constants: read-mode selectors and the occupancy-counter width helper.
package fifo_pkg;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  // Occupancy spans 0..depth inclusive, so it needs one bit more than a pointer.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ft_if.sv
// Handshake/status bundle between a FIFO and its user; master drives requests.
interface sync_fifo_ft_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);

  localparam int LW = level_w(DEPTH);

  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [LW-1:0]         level;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wr_en, din, rd_en,
    input  dout, valid, full, empty, almost_full, almost_empty, level, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, din, rd_en,
    output dout, valid, full, empty, almost_full, almost_empty, level, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// FIFO storage: register array with a clocked write port and a combinational read port.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately never reset; occupancy tracking decides what is live.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ft.sv
// Synchronous FIFO with optional first-word-fall-through read, level/threshold flags
// and one-cycle overflow/underflow error pulses.
module sync_fifo_ft
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int FWFT       = FWFT_OFF,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic            clk,
  input  logic            rst,
  sync_fifo_ft_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF   = LW'(AF_THRESH);
  localparam logic [LW-1:0] LVL_AE   = LW'(AE_THRESH);

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         level;
  logic [DATA_WIDTH-1:0] mem_rd;
  logic                  is_full;
  logic                  is_empty;
  logic                  rd_ok;
  logic                  wr_ok;
  logic                  ovf;
  logic                  udf;

  assign is_full  = (level == LVL_FULL);
  assign is_empty = (level == '0);

  // A full FIFO still takes a write when a pop frees a slot in the same cycle.
  assign rd_ok = bus.rd_en && !is_empty && !bus.flush;
  assign wr_ok = bus.wr_en && (!is_full || rd_ok) && !bus.flush;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (bus.din),
    .raddr (rd_ptr),
    .rdata (mem_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      ovf <= bus.wr_en && !wr_ok;
      udf <= bus.rd_en && is_empty;
    end
  end

  generate
    if (FWFT == FWFT_ON) begin : g_fwft
      // Head word is presented directly; forced to zero while nothing is live.
      assign bus.dout  = is_empty ? '0 : mem_rd;
      assign bus.valid = !is_empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_p1;
      logic                  vld_p1;

      // p0 -> p1: popped word registered, valid for the single following cycle
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_p1 <= '0;
          vld_p1  <= 1'b0;
        end else if (bus.flush) begin
          dout_p1 <= '0;
          vld_p1  <= 1'b0;
        end else begin
          vld_p1 <= rd_ok;
          if (rd_ok) dout_p1 <= mem_rd;
        end
      end

      assign bus.dout  = dout_p1;
      assign bus.valid = vld_p1;
    end
  endgenerate

  assign bus.level        = level;
  assign bus.full         = is_full;
  assign bus.empty        = is_empty;
  assign bus.almost_full  = (level >= LVL_AF);
  assign bus.almost_empty = (level <= LVL_AE);
  assign bus.overflow     = ovf;
  assign bus.underflow    = udf;

endmodule

// File: tb/tb_sync_fifo_ft.sv
// Drives a registered-read and a fall-through FIFO in lockstep and checks both
// against a queue-based reference model plus hand-computed vectors.
module tb_sync_fifo_ft;
  import fifo_pkg::*;

  localparam int DW = 8;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush, wr_en, rd_en;
  logic [DW-1:0] din;

  int checks   = 0;
  int failures = 0;

  sync_fifo_ft_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus0 ();
  sync_fifo_ft_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus1 ();

  assign bus0.flush = flush;
  assign bus0.wr_en = wr_en;
  assign bus0.rd_en = rd_en;
  assign bus0.din   = din;
  assign bus1.flush = flush;
  assign bus1.wr_en = wr_en;
  assign bus1.rd_en = rd_en;
  assign bus1.din   = din;

  sync_fifo_ft #(.DATA_WIDTH(DW), .DEPTH(DP), .FWFT(FWFT_OFF), .AF_THRESH(14), .AE_THRESH(2))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  sync_fifo_ft #(.DATA_WIDTH(DW), .DEPTH(DP), .FWFT(FWFT_ON), .AF_THRESH(14), .AE_THRESH(2))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  // Reference model: queue of live words plus the registered-read output view.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout0;
  logic          m_valid0, m_ovf, m_udf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dout0 = '0; m_valid0 = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  task automatic model_step(input logic f, input logic w, input logic r, input logic [DW-1:0] d);
    bit rd_acc, wr_acc;
    if (f) begin
      model_reset();
    end else begin
      rd_acc = r && (q.size() != 0);
      wr_acc = w && (q.size() < DP || rd_acc);
      m_ovf  = w && !wr_acc;
      m_udf  = r && (q.size() == 0);
      m_valid0 = rd_acc;
      if (rd_acc) m_dout0 = q.pop_front();
      if (wr_acc) q.push_back(d);
    end
  endtask

  task automatic check_model();
    int lvl;
    lvl = q.size();
    chk("level0", bus0.level, lvl);
    chk("level1", bus1.level, lvl);
    chk("full",   bus0.full,  lvl == DP);
    chk("empty",  bus0.empty, lvl == 0);
    chk("afull",  bus0.almost_full,  lvl >= 14);
    chk("aempty", bus0.almost_empty, lvl <= 2);
    chk("full1",  bus1.full,  lvl == DP);
    chk("empty1", bus1.empty, lvl == 0);
    chk("ovf0",   bus0.overflow,  m_ovf);
    chk("ovf1",   bus1.overflow,  m_ovf);
    chk("udf0",   bus0.underflow, m_udf);
    chk("udf1",   bus1.underflow, m_udf);
    chk("dout0",  bus0.dout,  m_dout0);
    chk("valid0", bus0.valid, m_valid0);
    chk("valid1", bus1.valid, lvl != 0);
    chk("dout1",  bus1.dout,  (lvl != 0) ? q[0] : 8'h00);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic f, input logic w, input logic r, input logic [DW-1:0] d);
    flush = f; wr_en = w; rd_en = r; din = d;
    tick();
    model_step(f, w, r, d);
    check_model();
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
  endtask

  task automatic check_reset_values();
    chk("rst_level",  bus0.level, 0);
    chk("rst_empty",  bus0.empty, 1);
    chk("rst_aempty", bus0.almost_empty, 1);
    chk("rst_full",   bus0.full, 0);
    chk("rst_afull",  bus0.almost_full, 0);
    chk("rst_dout0",  bus0.dout, 0);
    chk("rst_valid0", bus0.valid, 0);
    chk("rst_ovf",    bus0.overflow, 0);
    chk("rst_udf",    bus0.underflow, 0);
    chk("rst_valid1", bus1.valid, 0);
    chk("rst_dout1",  bus1.dout, 0);
  endtask

  typedef struct {
    logic          f, w, r;
    logic [DW-1:0] d;
    int            lvl;
    logic [DW-1:0] dout;
    logic          vld, ovf, udf;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b1, 8'h55, 1, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h55, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 8'h55, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h55, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 8'hA1, 1, 8'h55, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 8'hA2, 2, 8'h55, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 8'hA3, 2, 8'hA1, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 8'hB0, 0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h00, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    model_reset();
    tick(); tick();
    check_reset_values();
    rst = 1'b0;

    // Vector table: empty-FIFO simultaneous access, holds, flush priority
    for (int i = 0; i < 9; i++) begin
      apply(tbl[i].f, tbl[i].w, tbl[i].r, tbl[i].d);
      chk($sformatf("vec%0d_level", i), bus0.level, tbl[i].lvl);
      chk($sformatf("vec%0d_dout", i), bus0.dout, tbl[i].dout);
      chk($sformatf("vec%0d_valid", i), bus0.valid, tbl[i].vld);
      chk($sformatf("vec%0d_ovf", i), bus0.overflow, tbl[i].ovf);
      chk($sformatf("vec%0d_udf", i), bus0.underflow, tbl[i].udf);
    end

    // Fill to full, watching threshold crossings
    for (int i = 1; i <= 16; i++) begin
      apply(1'b0, 1'b1, 1'b0, 8'(i));
      if (i == 2)  chk("ae_at2",  bus0.almost_empty, 1);
      if (i == 3)  chk("ae_at3",  bus0.almost_empty, 0);
      if (i == 13) chk("af_at13", bus0.almost_full, 0);
      if (i == 14) chk("af_at14", bus0.almost_full, 1);
    end
    chk("fill_full", bus0.full, 1);
    chk("fill_level", bus0.level, 16);
    apply(1'b0, 1'b1, 1'b0, 8'h11);
    chk("ovf_pulse", bus0.overflow, 1);
    chk("ovf_level", bus0.level, 16);
    apply(1'b0, 1'b0, 1'b0, 8'h00);
    chk("ovf_single", bus0.overflow, 0);
    for (int i = 0; i < 16; i++) begin
      apply(1'b0, 1'b0, 1'b1, 8'h00);
      chk($sformatf("drain_dout%0d", i), bus0.dout, i + 1);
      chk($sformatf("drain_valid%0d", i), bus0.valid, 1);
    end
    apply(1'b0, 1'b0, 1'b0, 8'h00);
    chk("drain_valid_drop", bus0.valid, 0);
    chk("drain_empty", bus0.empty, 1);

    // Full with simultaneous write and read
    for (int i = 0; i < 16; i++) apply(1'b0, 1'b1, 1'b0, 8'h20 + 8'(i));
    apply(1'b0, 1'b1, 1'b1, 8'hAA);
    chk("fullrw_level", bus0.level, 16);
    chk("fullrw_ovf", bus0.overflow, 0);
    chk("fullrw_dout", bus0.dout, 8'h20);
    for (int i = 0; i < 16; i++) apply(1'b0, 1'b0, 1'b1, 8'h00);
    chk("fullrw_last", bus0.dout, 8'hAA);

    // Fall-through presentation from empty
    apply(1'b0, 1'b1, 1'b0, 8'h3C);
    chk("fwft_valid", bus1.valid, 1);
    chk("fwft_dout", bus1.dout, 8'h3C);
    apply(1'b0, 1'b0, 1'b1, 8'h00);
    chk("fwft_pop_valid", bus1.valid, 0);
    chk("fwft_pop_empty", bus1.empty, 1);

    // Flush at level 5 with a write pending
    for (int i = 0; i < 5; i++) apply(1'b0, 1'b1, 1'b0, 8'h60 + 8'(i));
    chk("pre_flush_level", bus0.level, 5);
    apply(1'b1, 1'b1, 1'b0, 8'h77);
    chk("flush_level", bus0.level, 0);
    chk("flush_empty", bus0.empty, 1);
    chk("flush_valid", bus0.valid, 0);
    chk("flush_ovf", bus0.overflow, 0);

    // Randomised mixed traffic with shifting read/write bias
    for (int i = 0; i < 400; i++) begin
      int wb, rb;
      wb = ((i / 50) % 2 == 0) ? 75 : 30;
      rb = ((i / 50) % 2 == 0) ? 30 : 75;
      apply(($urandom_range(0, 59) == 0), ($urandom_range(0, 99) < wb),
            ($urandom_range(0, 99) < rb), 8'($urandom));
    end

    // Reset in the middle of a burst, asserted between clock edges
    apply(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) apply(1'b0, 1'b1, 1'b0, 8'hD0 + 8'(i));
    wr_en = 1'b1; rd_en = 1'b1; din = 8'hDF;
    tick();
    model_step(1'b0, 1'b1, 1'b1, 8'hDF);
    chk("pre_rst_valid", bus0.valid, 1);
    chk("pre_rst_level", bus0.level, 4);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_reset_values();
    tick();
    wr_en = 1'b0; rd_en = 1'b0; din = '0;
    rst = 1'b0;
    apply(1'b0, 1'b1, 1'b0, 8'hE5);
    chk("post_rst_level", bus0.level, 1);
    apply(1'b0, 1'b0, 1'b1, 8'h00);
    chk("post_rst_dout", bus0.dout, 8'hE5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ft.md
SYNC_FIFO_FT -- requirements
Module: sync_fifo_ft

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, entry count; power of two, >= 4.
REQ-003 SHALL have parameter FWFT, default 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
REQ-004 SHALL have parameter AF_THRESH, default DEPTH-2, almost-full level threshold.
REQ-005 SHALL have parameter AE_THRESH, default 2, almost-empty level threshold.
REQ-006 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port flush  input  1  synchronous clear of contents.
REQ-009 SHALL have port wr_en  input  1  write request.
REQ-010 SHALL have port din  input  DATA_WIDTH  write data.
REQ-011 SHALL have port rd_en  input  1  read/pop request.
REQ-012 SHALL have port dout  output  DATA_WIDTH  read data.
REQ-013 SHALL have port valid  output  1  dout holds a valid word.
REQ-014 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-015 SHALL have port level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 SHALL have ports overflow, underflow  output  1 each  single-cycle error pulses.

Function
REQ-017 SHALL accept a write when wr_en && (!full || rd_accepted); accepted write stores din at wr_ptr, wr_ptr increments.
REQ-018 SHALL accept a read when rd_en && !empty; rd_ptr increments.
REQ-019 SHALL update level as +1 on write only, -1 on read only, unchanged on both or neither.
REQ-020 SHALL wrap wr_ptr/rd_ptr modulo DEPTH, with $clog2(DEPTH)-bit pointers.
REQ-021 SHALL decode full = (level==DEPTH), empty = (level==0), almost_full = (level>=AF_THRESH), almost_empty = (level<=AE_THRESH) combinationally from the level register.
REQ-022 SHALL, when full and wr_en && rd_en, accept both; level stays DEPTH; no overflow.
REQ-023 SHALL, when empty and wr_en && rd_en, reject the read, accept the write, pulse underflow; level becomes 1.
REQ-024 SHALL pulse overflow for one cycle when wr_en is asserted and the write is rejected; memory and wr_ptr unchanged.
REQ-025 SHALL pulse underflow for one cycle when rd_en && empty; dout, valid and rd_ptr otherwise behave as for no read.
REQ-026 SHALL, with FWFT=0, register mem[rd_ptr] into dout on an accepted read, assert valid for exactly the next cycle; dout holds its value otherwise.
REQ-027 SHALL, with FWFT=1, drive dout = mem[rd_ptr] and valid = !empty continuously; rd_en pops the presented word; write-to-valid latency is 1 cycle from an empty FIFO.
REQ-028 SHALL give flush priority over wr_en/rd_en: next cycle pointers = 0, level = 0, valid = 0, dout = 0, no overflow/underflow pulse.
REQ-029 SHALL not clear memory contents on flush or reset.

Reset
REQ-030 SHALL, while rst is high, force wr_ptr, rd_ptr, level, dout, valid, overflow, underflow to 0 asynchronously; empty and almost_empty = 1; full and almost_full = 0.
REQ-031 SHALL abandon any in-flight read/write on reset mid-operation and accept the first request in the first rising edge after rst deasserts.

Structure
REQ-032 SHALL take mode constants (FWFT_OFF = 0, FWFT_ON = 1) and the level-width function from shared package fifo_pkg.
REQ-033 SHALL instantiate one sub-module fifo_mem: DEPTH x DATA_WIDTH register array, synchronous write port, asynchronous read port.
REQ-034 SHALL hold pointer, level and flag logic in sync_fifo_ft.

Verification
REQ-035 SHALL cover: DEPTH=16, FWFT=0, write 0x01..0x10, one more write -> full=1, overflow one pulse, level=16; read 16 -> data 0x01..0x10 in order with valid one cycle after each rd_en.
REQ-036 SHALL cover: full, wr_en && rd_en with din=0xAA -> level stays 16, no overflow, 0xAA read out last.
REQ-037 SHALL cover: empty, wr_en && rd_en with din=0x55 -> underflow pulse, level=1, next read returns 0x55.
REQ-038 SHALL cover: FWFT=1, write 0x3C to empty -> next cycle valid=1, dout=0x3C without rd_en; rd_en -> valid=0, empty=1.
REQ-039 SHALL cover: level 5 with wr_en asserted, flush pulse -> level=0, empty=1, valid=0, no overflow; pointer wrap over 40 mixed operations checked against a scoreboard model.
REQ-040 SHALL cover: AF_THRESH=14, AE_THRESH=2 -> almost_full rises at level 14, almost_empty falls at level 3; rst mid-burst -> all outputs at reset values immediately.
